// File: rtl/uart_baud_gen_pkg.sv
// Shared definitions for the UART baud/oversample timing generator.
//   - Default widths for the divisor, fractional divisor and OSR fields.
//   - Legal OSR lower bound and the channel indices used by the top level.
//   - baud_cfg_t: one complete timing configuration at the default widths.
package uart_baud_gen_pkg;

  localparam int DIV_W_DEF   = 16;
  localparam int FRAC_W_DEF  = 4;
  localparam int OSR_W_DEF   = 5;
  localparam int OSR_MAX_DEF = 16;
  localparam int OSR_MIN     = 4;

  localparam int   NUM_CH = 2;
  localparam logic CH_RX  = 1'b0;
  localparam logic CH_TX  = 1'b1;

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
    logic [OSR_W_DEF-1:0]  osr;
  } baud_cfg_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Configuration / strobe bundle between the UART register block and the
// baud generator.
//   master : register block side - drives enable, divisors, osr, sync clears;
//            receives baud_tick, rx_sample_pulse, tx_bit_pulse, cfg_err.
//   slave  : baud generator side (mirror image of master).
interface uart_baud_gen_if
  import uart_baud_gen_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OSR_W  = OSR_W_DEF
);

  logic              enable;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic [OSR_W-1:0]  osr;
  logic              rx_sync_clr;
  logic              tx_sync_clr;
  logic              baud_tick;
  logic              rx_sample_pulse;
  logic              tx_bit_pulse;
  logic              cfg_err;

  modport master (
    output enable, div_int, div_frac, osr, rx_sync_clr, tx_sync_clr,
    input  baud_tick, rx_sample_pulse, tx_bit_pulse, cfg_err
  );

  modport slave (
    input  enable, div_int, div_frac, osr, rx_sync_clr, tx_sync_clr,
    output baud_tick, rx_sample_pulse, tx_bit_pulse, cfg_err
  );

endinterface

// File: rtl/uart_baud_gen_chan.sv
// One timing channel: fractional prescaler plus oversample phase counter.
//   pclk, presetn  : clock, asynchronous active-low reset
//   run_i          : channel may count; when low the channel is held cleared
//   clr_i          : realign; channel is cleared next cycle, no tick this cycle
//   div_int_i      : integer pclk cycles per tick
//   div_frac_i     : fractional extra cycles per tick (1/2^FRAC_W units)
//   osr_i          : ticks per bit
//   tick_o         : combinational tick (last cycle of a prescaler period)
//   ph_o           : phase count before this tick is applied
//   osr_o          : osr captured for the current period
module uart_baud_gen_chan
  import uart_baud_gen_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OSR_W  = OSR_W_DEF
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              run_i,
  input  logic              clr_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic [OSR_W-1:0]  osr_i,
  output logic              tick_o,
  output logic [OSR_W-1:0]  ph_o,
  output logic [OSR_W-1:0]  osr_o
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);
  localparam logic [DIV_W:0]   PER_ONE = (DIV_W+1)'(1);
  localparam logic [OSR_W-1:0] OSR_ONE = OSR_W'(1);

  // Period length needs one extra bit: div_int all-ones plus a carry.
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W:0]    per_q, per_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [OSR_W-1:0]  ph_q, ph_d;
  logic [OSR_W-1:0]  osr_q, osr_d;
  logic [FRAC_W:0]   acc_sum;
  logic              tick;

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, div_frac_i};
    // A legal period is at least 2 cycles, so the tick never lands on the
    // period-start cycle (cnt==0); per_q/osr_q are therefore always current
    // whenever a tick is possible.
    tick  = run_i && !clr_i && (cnt_q != '0) && ({1'b0, cnt_q} == (per_q - PER_ONE));
    cnt_d = cnt_q;
    per_d = per_q;
    acc_d = acc_q;
    ph_d  = ph_q;
    osr_d = osr_q;
    if (!run_i || clr_i) begin
      cnt_d = '0;
      per_d = '0;
      acc_d = '0;
      ph_d  = '0;
      osr_d = '0;
    end else begin
      if (cnt_q == '0) begin
        // Period start: capture configuration and fold in the fraction.
        acc_d = acc_sum[FRAC_W-1:0];
        per_d = {1'b0, div_int_i} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
        osr_d = osr_i;
      end
      if (tick) begin
        cnt_d = '0;
        // >= rather than == so a phase left beyond a shrunken osr still wraps.
        ph_d  = (ph_q >= (osr_q - OSR_ONE)) ? '0 : (ph_q + OSR_ONE);
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
      per_q <= '0;
      acc_q <= '0;
      ph_q  <= '0;
      osr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
      acc_q <= acc_d;
      ph_q  <= ph_d;
      osr_q <= osr_d;
    end
  end

  assign tick_o = tick;
  assign ph_o   = ph_q;
  assign osr_o  = osr_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud/oversample timing generator with independent RX and TX channels.
//   pclk    : core clock, rising edge
//   presetn : asynchronous active-low reset
//   bus     : slave side of uart_baud_gen_if
//             in : enable, div_int, div_frac, osr, rx_sync_clr, tx_sync_clr
//             out: baud_tick (TX oversample tick), rx_sample_pulse (RX mid-bit),
//                  tx_bit_pulse (TX bit boundary), cfg_err (illegal config level)
// All outputs are registered, one cycle after the internal event.
module uart_baud_gen
  import uart_baud_gen_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int OSR_W   = OSR_W_DEF,
  parameter int OSR_MAX = OSR_MAX_DEF
) (
  input logic            pclk,
  input logic            presetn,
  uart_baud_gen_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [OSR_W-1:0] OSR_LO  = OSR_W'(OSR_MIN);
  localparam logic [OSR_W-1:0] OSR_HI  = OSR_W'(OSR_MAX);
  localparam logic [OSR_W-1:0] OSR_ONE = OSR_W'(1);

  logic             cfg_err_q, cfg_err_d;
  logic             run;
  logic [1:0]       clr;
  logic [1:0]       tick;
  logic [OSR_W-1:0] ph      [NUM_CH];
  logic [OSR_W-1:0] osr_per [NUM_CH];
  logic             rx_mid, tx_wrap;
  logic             baud_tick_q, rx_sample_q, tx_bit_q;

  assign clr[CH_RX] = bus.rx_sync_clr;
  assign clr[CH_TX] = bus.tx_sync_clr;

  always_comb begin
    cfg_err_d = (bus.div_int < DIV_MIN) || (bus.osr < OSR_LO) ||
                bus.osr[0] || (bus.osr > OSR_HI);
    run       = bus.enable && !cfg_err_q;
    // RX strobe on the tick that advances the phase to osr/2 (mid-bit).
    rx_mid    = tick[CH_RX] && ((ph[CH_RX] + OSR_ONE) == (osr_per[CH_RX] >> 1));
    // TX strobe on the tick that wraps the phase back to 0 (bit boundary).
    tx_wrap   = tick[CH_TX] && (ph[CH_TX] >= (osr_per[CH_TX] - OSR_ONE));
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    uart_baud_gen_chan #(
      .DIV_W  (DIV_W),
      .FRAC_W (FRAC_W),
      .OSR_W  (OSR_W)
    ) u_chan (
      .pclk       (pclk),
      .presetn    (presetn),
      .run_i      (run),
      .clr_i      (clr[gi]),
      .div_int_i  (bus.div_int),
      .div_frac_i (bus.div_frac),
      .osr_i      (bus.osr),
      .tick_o     (tick[gi]),
      .ph_o       (ph[gi]),
      .osr_o      (osr_per[gi])
    );
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cfg_err_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      rx_sample_q <= 1'b0;
      tx_bit_q    <= 1'b0;
    end else begin
      cfg_err_q   <= cfg_err_d;
      baud_tick_q <= tick[CH_TX];
      rx_sample_q <= rx_mid;
      tx_bit_q    <= tx_wrap;
    end
  end

  assign bus.baud_tick       = baud_tick_q;
  assign bus.rx_sample_pulse = rx_sample_q;
  assign bus.tx_bit_pulse    = tx_bit_q;
  assign bus.cfg_err         = cfg_err_q;

endmodule
